rv32i_fetch_unit: RTL and testbench

- Instruction fetch stage that sits directly upstream of the RV32I decoder.
- Generates sequential PCs and issues word requests to instruction memory over a valid/ready request channel.
- Accepts in-order responses and buffers them in a small FIFO that presents instruction, PC and fault status to the decoder stage.
- Handles redirects (branch, jump, trap), discards stale in-flight responses, and stops fetching after a fault until the next redirect.

---
 rtl/rv32i_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_rv32i_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch stage: sequential PC generation, credit-limited memory
// requests, in-order response buffering and redirect/fault handling.
module rv32i_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [1:0]  out_fault
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]  DEPTH_W   = (CW + 1)'(DEPTH);
    localparam logic [31:0]  NOP_INSTR = 32'h0000_0013;
    localparam logic [1:0]   FAULT_NONE   = 2'b00;
    localparam logic [1:0]   FAULT_ACCESS = 2'b01;
    localparam logic [1:0]   FAULT_ALIGN  = 2'b10;

    typedef enum logic {RUN, HALT} state_t;

    state_t          state_reg, state_next;
    logic            armed_reg;
    logic [31:0]     fetch_pc_reg, fetch_pc_next;
    logic [31:0]     rsp_pc_reg, rsp_pc_next;
    logic [CW-1:0]   inflight_reg, inflight_next;
    logic [CW-1:0]   discard_reg, discard_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]   push_ptr;

    logic [31:0]     instr_mem [DEPTH];
    logic [31:0]     pc_mem    [DEPTH];
    logic [1:0]      fault_mem [DEPTH];

    logic            push;
    logic [31:0]     push_instr;
    logic [31:0]     push_pc;
    logic [1:0]      push_fault;
    logic            req_fire;
    logic            pop;
    logic            fifo_nonempty;
    logic [CW:0]     occupancy;

    assign fifo_nonempty = (count_reg != '0);
    assign occupancy     = {1'b0, inflight_reg} + {1'b0, count_reg};

    // armed_reg keeps the request line low until the first edge after reset release.
    assign imem_req_valid = armed_reg && (state_reg == RUN) && !redirect_valid
                            && (occupancy < DEPTH_W);
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign out_valid = fifo_nonempty && !redirect_valid;
    assign out_instr = fifo_nonempty ? instr_mem[rd_ptr_reg] : '0;
    assign out_pc    = fifo_nonempty ? pc_mem[rd_ptr_reg]    : '0;
    assign out_fault = fifo_nonempty ? fault_mem[rd_ptr_reg] : FAULT_NONE;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = req_fire ? fetch_pc_reg + 32'd4 : fetch_pc_reg;
        rsp_pc_next   = rsp_pc_reg;
        inflight_next = inflight_reg + CW'(req_fire) - CW'(imem_rsp_valid);
        discard_next  = discard_reg;
        push          = 1'b0;
        push_instr    = imem_rsp_data;
        push_pc       = rsp_pc_reg;
        push_fault    = FAULT_NONE;

        if (imem_rsp_valid) begin
            if (discard_reg != '0) begin
                discard_next = discard_reg - CW'(1);
            end else begin
                push        = 1'b1;
                rsp_pc_next = rsp_pc_reg + 32'd4;
                if (imem_rsp_err) begin
                    // Everything still outstanding belongs to the faulted stream.
                    push_instr   = NOP_INSTR;
                    push_fault   = FAULT_ACCESS;
                    discard_next = inflight_next;
                    state_next   = HALT;
                end
            end
        end

        // Redirect overrides any response handling done above.
        if (redirect_valid) begin
            fetch_pc_next = redirect_pc;
            rsp_pc_next   = redirect_pc;
            discard_next  = inflight_next;
            push          = 1'b0;
            state_next    = RUN;
            if (redirect_pc[1:0] != 2'b00) begin
                push       = 1'b1;
                push_instr = NOP_INSTR;
                push_pc    = redirect_pc;
                push_fault = FAULT_ALIGN;
                state_next = HALT;
            end
        end

        push_ptr    = redirect_valid ? '0 : wr_ptr_reg;
        wr_ptr_next = push_ptr + AW'(push);
        rd_ptr_next = redirect_valid ? '0 : rd_ptr_reg + AW'(pop);
        count_next  = (redirect_valid ? '0 : count_reg - CW'(pop)) + CW'(push);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= RUN;
            armed_reg    <= 1'b0;
            fetch_pc_reg <= RESET_PC;
            rsp_pc_reg   <= RESET_PC;
            inflight_reg <= '0;
            discard_reg  <= '0;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            armed_reg    <= 1'b1;
            fetch_pc_reg <= fetch_pc_next;
            rsp_pc_reg   <= rsp_pc_next;
            inflight_reg <= inflight_next;
            discard_reg  <= discard_next;
            count_reg    <= count_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
        end
    end

    // Entry storage needs no reset: reads are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[push_ptr] <= push_instr;
            pc_mem[push_ptr]    <= push_pc;
            fault_mem[push_ptr] <= push_fault;
        end
    end
endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Randomized scoreboard bench for rv32i_fetch_unit with an epoch-based memory/stream model.
module tb_rv32i_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [1:0]  out_fault;

    rv32i_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .imem_rsp_err(imem_rsp_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_fault(out_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_pc;
        int          epoch;
        int          due;
        bit          err;
    } mreq_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  fault;
    } exp_t;

    mreq_t       pend_q[$];
    exp_t        exp_q[$];
    int          checks, errors, cycle, epoch, pops;
    bit          dead;
    logic [31:0] next_addr;
    int          lat_min, lat_max, p_ready, p_out_ready, p_redirect, p_err;
    bit          force_redir;
    logic [31:0] force_pc;
    logic [31:0] err_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] pick_target();
        int sel;
        logic [31:0] r;
        sel = $urandom_range(0, 5);
        r   = $urandom;
        case (sel)
            0: return 32'h0000_0100;
            1: return 32'h0000_0040;
            2: return 32'h0000_0102;
            3: return 32'hFFFF_FFFC;
            4: return {r[31:2], 2'b00};
            default: return {r[31:2], 2'b01};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
        check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_out_instr"}, out_instr, 32'd0);
        check({tag, "_out_pc"}, out_pc, 32'd0);
        check({tag, "_out_fault"}, {30'b0, out_fault}, 32'd0);
    endtask

    task automatic set_cfg(input int lmin, input int lmax, input int pr, input int po,
                           input int pd, input int pe);
        lat_min = lmin; lat_max = lmax; p_ready = pr;
        p_out_ready = po; p_redirect = pd; p_err = pe;
    endtask

    // Drives all inputs for one cycle, 1 time unit after the rising edge.
    task automatic drive_cycle();
        @(posedge clk);
        #1;
        cycle++;
        imem_req_ready = ($urandom_range(0, 99) < p_ready);
        out_ready      = ($urandom_range(0, 99) < p_out_ready);
        if (rst_n && pend_q.size() > 0 && pend_q[0].due <= cycle) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_q[0].addr);
            imem_rsp_err   = pend_q[0].err;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            imem_rsp_err   = 1'b0;
        end
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
            force_redir    = 1'b0;
        end else if (rst_n && $urandom_range(0, 99) < p_redirect) begin
            redirect_valid = 1'b1;
            redirect_pc    = pick_target();
        end else begin
            redirect_valid = 1'b0;
            redirect_pc    = $urandom;
        end
    endtask

    task automatic run(input int n);
        repeat (n) drive_cycle();
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        force_redir = 1'b1;
        force_pc    = pc;
        drive_cycle();
    endtask

    task automatic reset_pulse();
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        redirect_valid = 1'b0;
        run(3);
        rst_n = 1'b1;
    endtask

    // Reference model: memory, request legality and the expected decoder stream.
    always begin : model
        mreq_t       r;
        bit          allowed;
        @(negedge clk);
        if (!rst_n) begin
            pend_q.delete();
            exp_q.delete();
            epoch++;
            dead      = 1'b0;
            next_addr = RESET_PC;
        end else begin
            if (imem_req_valid) begin
                allowed = !dead && !redirect_valid && ((pend_q.size() + exp_q.size()) < DEPTH);
                check("req_allowed", {31'b0, allowed}, 32'd1);
                if (imem_req_ready) begin
                    check("req_addr", imem_req_addr, next_addr);
                    r.addr   = imem_req_addr;
                    r.exp_pc = next_addr;
                    r.epoch  = epoch;
                    r.due    = cycle + $urandom_range(lat_min, lat_max);
                    r.err    = (next_addr == err_addr) || ($urandom_range(0, 99) < p_err);
                    pend_q.push_back(r);
                    next_addr = next_addr + 32'd4;
                end
            end
            if (imem_rsp_valid && pend_q.size() > 0) begin
                r = pend_q.pop_front();
                if (r.epoch == epoch && !dead) begin
                    if (r.err) begin
                        exp_q.push_back('{instr: NOP, pc: r.exp_pc, fault: 2'b01});
                        dead = 1'b1;
                    end else begin
                        exp_q.push_back('{instr: mem_word(r.exp_pc), pc: r.exp_pc, fault: 2'b00});
                    end
                end
            end
            if (redirect_valid) begin
                check("redirect_out_valid", {31'b0, out_valid}, 32'd0);
                exp_q.delete();
                epoch++;
                if (redirect_pc[1:0] != 2'b00) begin
                    exp_q.push_back('{instr: NOP, pc: redirect_pc, fault: 2'b10});
                    dead = 1'b1;
                end else begin
                    dead      = 1'b0;
                    next_addr = redirect_pc;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the decoder side consumes an entry.
    always begin : monitor
        exp_t        e;
        bit          prev_hold;
        logic [31:0] prev_instr, prev_pc;
        @(negedge clk);
        #2;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && !redirect_valid) begin
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_instr", out_instr, prev_instr);
                check("hold_pc", out_pc, prev_pc);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out actual pc=%h required=no entry (cycle %0d)", out_pc, cycle);
                end else begin
                    e = exp_q.pop_front();
                    check("out_instr", out_instr, e.instr);
                    check("out_pc", out_pc, e.pc);
                    check("out_fault", {30'b0, out_fault}, {30'b0, e.fault});
                    pops++;
                end
            end
            prev_hold  = out_valid && !out_ready;
            prev_instr = out_instr;
            prev_pc    = out_pc;
        end
    end

    initial begin
        checks = 0; errors = 0; cycle = 0; pops = 0; epoch = 0;
        dead = 1'b0; next_addr = RESET_PC;
        force_redir = 1'b0; force_pc = '0; err_addr = 32'h1;
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        imem_rsp_err = 1'b0; out_ready = 1'b0;
        set_cfg(1, 1, 100, 100, 0, 0);
        #2;
        check_outputs_zero("reset");
        run(3);
        rst_n = 1'b1;

        // Sequential fetch, single-cycle memory.
        run(40);
        // Decoder backpressure then release.
        set_cfg(1, 1, 100, 0, 0, 0);
        run(10);
        set_cfg(1, 1, 100, 100, 0, 0);
        run(20);
        // Redirect with requests outstanding on a slow memory.
        set_cfg(3, 3, 100, 100, 0, 0);
        run(10);
        redirect_to(32'h0000_0100);
        run(20);
        // Access fault at 0x8, then recovery through redirect.
        set_cfg(1, 1, 100, 100, 0, 0);
        err_addr = 32'h0000_0008;
        redirect_to(32'h0000_0000);
        run(20);
        err_addr = 32'h1;
        redirect_to(32'h0000_0040);
        run(20);
        // Misaligned redirect: fault entry and halted fetch.
        redirect_to(32'h0000_0102);
        run(10);
        #1;
        check("halt_req_valid", {31'b0, imem_req_valid}, 32'd0);
        redirect_to(32'h0000_0200);
        run(10);
        // Address wrap, then asynchronous reset mid-burst.
        redirect_to(32'hFFFF_FFFC);
        run(6);
        reset_pulse();
        run(20);

        // Randomized traffic with redirects, faults and stalls.
        set_cfg(1, 4, 70, 70, 3, 3);
        run(1500);
        reset_pulse();
        run(1500);

        checks++;
        if (pops < 200) begin
            errors++;
            $display("FAIL throughput actual=%0d required>=200 instructions", pops);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
